// File: rtl/cache_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : cache_exerciser
//  Description : Traffic generator and checker for the 32-bit cache front-end.
//                Sweeps an address range, writes addr ^ PATTERN_SEED (optionally
//                inverted), reads it back and verifies it. It counts mismatches
//                and read timeouts for status reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_exerciser #(
    parameter logic [31:0] ADDR_START     = 32'h0000_0000,
    parameter logic [31:0] ADDR_END       = 32'h0000_00FC,
    parameter logic [31:0] STRIDE         = 32'd4,
    parameter logic [31:0] PATTERN_SEED   = 32'hA5A5_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ERR_WIDTH      = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 invert,
    output logic [31:0]          address,
    output logic [31:0]          data_in,
    output logic [3:0]           write_enable,
    input  logic [31:0]          data_out,
    input  logic                 data_out_ready,
    input  logic                 busy,
    output logic                 running,
    output logic                 done,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic [31:0]          first_err_addr,
    output logic                 timeout_seen
);

    // Timeout counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int unsigned c_cnt_w = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_to_limit = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [3:0] c_we_write = 4'b1111;
    localparam logic [3:0] c_we_read  = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_ADV      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t               r_state, w_state;
    logic                 r_mode_both, w_mode_both;   // write phase followed by read phase
    logic                 r_phase_rd, w_phase_rd;     // current phase is the read phase
    logic                 r_invert, w_invert;
    logic [31:0]          r_addr, w_addr;
    logic [31:0]          r_data, w_data;
    logic [3:0]           r_we, w_we;
    logic                 r_running, w_running;
    logic                 r_done, w_done;
    logic [ERR_WIDTH-1:0] r_err_cnt, w_err_cnt;
    logic [31:0]          r_first_err, w_first_err;
    logic                 r_timeout, w_timeout;
    logic [c_cnt_w-1:0]   r_to_cnt, w_to_cnt;

    logic [31:0]          w_pattern;
    logic [32:0]          w_next_addr;
    logic                 w_err_event;
    logic                 w_sweep_end;

    // Next-state, datapath and error bookkeeping for the sweep sequencer.
    always_comb begin
        w_state     = r_state;
        w_mode_both = r_mode_both;
        w_phase_rd  = r_phase_rd;
        w_invert    = r_invert;
        w_addr      = r_addr;
        w_data      = r_data;
        w_we        = r_we;
        w_running   = r_running;
        w_done      = r_done;
        w_err_cnt   = r_err_cnt;
        w_first_err = r_first_err;
        w_timeout   = r_timeout;
        w_to_cnt    = r_to_cnt;
        w_err_event = 1'b0;

        w_pattern   = (r_addr ^ PATTERN_SEED) ^ {32{r_invert}};
        // 33-bit add so a sweep near the top of memory stops instead of wrapping.
        w_next_addr = {1'b0, r_addr} + {1'b0, STRIDE};
        w_sweep_end = w_next_addr[32] || (w_next_addr > {1'b0, ADDR_END});

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_mode_both = mode[1];
                    w_phase_rd  = (mode == 2'd1);
                    w_invert    = invert;
                    w_err_cnt   = '0;
                    w_first_err = '0;
                    w_timeout   = 1'b0;
                    w_done      = 1'b0;
                    w_addr      = ADDR_START;
                    w_running   = 1'b1;
                    w_state     = (mode == 2'd1) ? S_RD_ISSUE : S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                if (!busy) begin
                    w_data  = w_pattern;
                    w_we    = c_we_write;
                    w_state = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                // Byte enables are only ever high for the first cycle here.
                w_we = c_we_read;
                if (!busy) begin
                    w_state = S_ADV;
                end
            end
            S_RD_ISSUE: begin
                if (!busy) begin
                    w_we     = c_we_read;
                    w_to_cnt = '0;
                    w_state  = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (data_out_ready) begin
                    w_err_event = (data_out != w_pattern);
                    w_state     = S_ADV;
                end else if (r_to_cnt == c_to_limit) begin
                    w_timeout   = 1'b1;
                    w_err_event = 1'b1;
                    w_state     = S_ADV;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            S_ADV: begin
                if (w_sweep_end) begin
                    if (!r_phase_rd && r_mode_both) begin
                        w_addr     = ADDR_START;
                        w_phase_rd = 1'b1;
                        w_state    = S_RD_ISSUE;
                    end else begin
                        w_running = 1'b0;
                        w_done    = 1'b1;
                        w_state   = S_DONE;
                    end
                end else begin
                    w_addr  = w_next_addr[31:0];
                    w_state = r_phase_rd ? S_RD_ISSUE : S_WR_ISSUE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Only the first error of a sweep records its address; the count saturates.
        if (w_err_event) begin
            if (r_err_cnt == '0) begin
                w_first_err = r_addr;
            end
            if (r_err_cnt != '1) begin
                w_err_cnt = r_err_cnt + 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any sweep immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_mode_both <= 1'b0;
            r_phase_rd  <= 1'b0;
            r_invert    <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= c_we_read;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_timeout   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state;
            r_mode_both <= w_mode_both;
            r_phase_rd  <= w_phase_rd;
            r_invert    <= w_invert;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_we        <= w_we;
            r_running   <= w_running;
            r_done      <= w_done;
            r_err_cnt   <= w_err_cnt;
            r_first_err <= w_first_err;
            r_timeout   <= w_timeout;
            r_to_cnt    <= w_to_cnt;
        end
    end

    assign address        = r_addr;
    assign data_in        = r_data;
    assign write_enable   = r_we;
    assign running        = r_running;
    assign done           = r_done;
    assign error_count    = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign timeout_seen   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cache_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_exerciser
//  Description : Directed self-checking bench for cache_exerciser. Three DUT
//                instances cover the default sweep, a stride-8 sweep with a
//                busy cache, and a sweep at the top of the address space.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_exerciser;

    localparam logic [31:0] c_seed = 32'hA5A5_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start          [3];
    logic [1:0]  mode           [3];
    logic        invert         [3];
    logic [31:0] address        [3];
    logic [31:0] data_in        [3];
    logic [3:0]  write_enable   [3];
    logic [31:0] data_out       [3];
    logic        data_out_ready [3];
    logic        busy           [3];
    logic        running        [3];
    logic        done           [3];
    logic [15:0] error_count    [3];
    logic [31:0] first_err_addr [3];
    logic        timeout_seen   [3];

    int n_checks = 0;
    int n_errs   = 0;

    cache_exerciser u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[0]), .mode(mode[0]),
        .invert(invert[0]), .address(address[0]), .data_in(data_in[0]),
        .write_enable(write_enable[0]), .data_out(data_out[0]),
        .data_out_ready(data_out_ready[0]), .busy(busy[0]), .running(running[0]),
        .done(done[0]), .error_count(error_count[0]), .first_err_addr(first_err_addr[0]),
        .timeout_seen(timeout_seen[0]));

    cache_exerciser #(.ADDR_END(32'h0000_001C), .STRIDE(32'd8)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[1]), .mode(mode[1]),
        .invert(invert[1]), .address(address[1]), .data_in(data_in[1]),
        .write_enable(write_enable[1]), .data_out(data_out[1]),
        .data_out_ready(data_out_ready[1]), .busy(busy[1]), .running(running[1]),
        .done(done[1]), .error_count(error_count[1]), .first_err_addr(first_err_addr[1]),
        .timeout_seen(timeout_seen[1]));

    cache_exerciser #(.ADDR_START(32'hFFFF_FFF8), .ADDR_END(32'hFFFF_FFFC), .STRIDE(32'd8)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[2]), .mode(mode[2]),
        .invert(invert[2]), .address(address[2]), .data_in(data_in[2]),
        .write_enable(write_enable[2]), .data_out(data_out[2]),
        .data_out_ready(data_out_ready[2]), .busy(busy[2]), .running(running[2]),
        .done(done[2]), .error_count(error_count[2]), .first_err_addr(first_err_addr[2]),
        .timeout_seen(timeout_seen[2]));

    initial forever #5 sys_clk = ~sys_clk;

    // Per-instance sweep parameters as the bench understands them.
    function automatic logic [31:0] f_start(input int k);
        return (k == 2) ? 32'hFFFF_FFF8 : 32'h0;
    endfunction
    function automatic logic [31:0] f_end(input int k);
        case (k)
            1:       return 32'h0000_001C;
            2:       return 32'hFFFF_FFFC;
            default: return 32'h0000_00FC;
        endcase
    endfunction
    function automatic logic [31:0] f_stride(input int k);
        return (k == 0) ? 32'd4 : 32'd8;
    endfunction
    function automatic logic [31:0] f_pat(input logic [31:0] a, input logic inv);
        return inv ? ~(a ^ c_seed) : (a ^ c_seed);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input int got, input int limit);
        n_checks++;
        n_errs++;
        $display("FAIL %s: got %0d, limit %0d", name, got, limit);
    endtask

    // ---------------- cache model ----------------
    logic [31:0] mem [logic [33:0]];
    logic        corrupt_en   [3];
    logic [31:0] corrupt_addr [3];
    logic        noready_en   [3];
    logic [31:0] noready_addr [3];
    int          bcnt         [3];
    logic        cm_prev_run  [3];
    logic [31:0] cm_prev_addr [3];

    // Memory with optional read corruption / missing ready; instance 1 holds
    // busy for 3 cycles whenever a new request address appears.
    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [33:0] key;
            logic [31:0] rd;
            logic        trig;
            key = {2'(k), address[k]};
            if (write_enable[k] == 4'hF) mem[key] = data_in[k];
            trig = (running[k] && !cm_prev_run[k]) || (address[k] != cm_prev_addr[k]);
            cm_prev_run[k]  = running[k];
            cm_prev_addr[k] = address[k];
            if (k == 1 && trig) bcnt[k] = 3;
            busy[k] = (bcnt[k] != 0);
            if (bcnt[k] != 0) bcnt[k] = bcnt[k] - 1;
            rd = mem.exists(key) ? mem[key] : 32'h0;
            if (corrupt_en[k] && address[k] == corrupt_addr[k]) rd = rd ^ 32'h1;
            data_out[k]       = rd;
            data_out_ready[k] = !(noready_en[k] && address[k] == noready_addr[k]);
        end
    end

    // ---------------- reference model ----------------
    int          act = 0;
    logic [31:0] wr_exp  [$];
    logic [31:0] exp_seq [$];
    int          wr_pos  = 0;
    int          seq_pos = 0;
    logic        exp_inv = 1'b0;
    int          exp_err = 0;
    logic [31:0] exp_first = 0;
    logic        exp_to = 1'b0;

    // Work out the visited addresses, writes and final status of one sweep.
    task automatic plan(input int k, input logic [1:0] m, input logic inv);
        logic [31:0] lst [$];
        logic [32:0] nxt;
        logic [31:0] a;
        bit          more;
        lst.delete();
        a = f_start(k);
        more = 1;
        while (more) begin
            lst.push_back(a);
            nxt = {1'b0, a} + {1'b0, f_stride(k)};
            if (nxt[32] || nxt > {1'b0, f_end(k)}) more = 0;
            else a = nxt[31:0];
        end
        wr_exp.delete();
        exp_seq.delete();
        if (m != 2'd1) begin
            foreach (lst[i]) begin
                wr_exp.push_back(lst[i]);
                exp_seq.push_back(lst[i]);
            end
        end
        exp_err = 0; exp_first = 0; exp_to = 1'b0;
        if (m != 2'd0) begin
            foreach (lst[i]) begin
                bit to_hit, bad;
                if (exp_seq.size() == 0 || exp_seq[exp_seq.size()-1] != lst[i])
                    exp_seq.push_back(lst[i]);
                to_hit = noready_en[k] && lst[i] == noready_addr[k];
                bad = to_hit || (corrupt_en[k] && lst[i] == corrupt_addr[k]);
                if (bad) begin
                    if (exp_err == 0) exp_first = lst[i];
                    exp_err++;
                    if (to_hit) exp_to = 1'b1;
                end
            end
        end
        wr_pos = 0; seq_pos = 0; exp_inv = inv; act = k;
    endtask

    // ---------------- per-cycle compare ----------------
    logic [3:0]  ck_prev_we   = 4'h0;
    logic        ck_prev_run  = 1'b0;
    logic [31:0] ck_prev_addr = 32'h0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (write_enable[act] != 4'h0) begin
                chk("we_value", write_enable[act], 4'hF);
                chk("we_pulse", ck_prev_we, 4'h0);
                if (wr_pos < wr_exp.size()) begin
                    chk("wr_addr", address[act], wr_exp[wr_pos]);
                    chk("wr_data", data_in[act], f_pat(wr_exp[wr_pos], exp_inv));
                end else begin
                    fail_now("wr_extra", wr_pos + 1, wr_exp.size());
                end
                wr_pos++;
            end
            if (running[act] && (!ck_prev_run || address[act] != ck_prev_addr)) begin
                if (seq_pos < exp_seq.size()) chk("addr_seq", address[act], exp_seq[seq_pos]);
                else fail_now("addr_extra", seq_pos + 1, exp_seq.size());
                seq_pos++;
            end
            ck_prev_we   = write_enable[act];
            ck_prev_run  = running[act];
            ck_prev_addr = address[act];
        end
    end

    // ---------------- stimulus ----------------
    task automatic kick(input int k, input logic [1:0] m, input logic inv);
        @(posedge sys_clk); #1;
        mode[k] = m; invert[k] = inv; start[k] = 1'b1;
        @(posedge sys_clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, input int glitch_at);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (i == glitch_at) begin start[k] = 1'b1; mode[k] = 2'd1; end
            else start[k] = 1'b0;
            @(posedge sys_clk); #1;
            if (done[k]) begin ok = 1; break; end
        end
        start[k] = 1'b0;
        if (!ok) fail_now("done_timeout", budget, budget);
    endtask

    task automatic final_checks(input int k);
        chk("error_count", error_count[k], exp_err);
        chk("first_err_addr", first_err_addr[k], exp_first);
        chk("timeout_seen", timeout_seen[k], exp_to);
        chk("running_end", running[k], 1'b0);
        chk("done_end", done[k], 1'b1);
        chk("seq_len", seq_pos, exp_seq.size());
        chk("wr_len", wr_pos, wr_exp.size());
    endtask

    task automatic run(input int k, input logic [1:0] m, input logic inv, input int glitch_at);
        plan(k, m, inv);
        kick(k, m, inv);
        wait_done(k, 4000, glitch_at);
        final_checks(k);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; mode[k] = 2'd0; invert[k] = 1'b0;
            corrupt_en[k] = 1'b0; noready_en[k] = 1'b0;
            corrupt_addr[k] = 32'h0; noready_addr[k] = 32'h0;
            bcnt[k] = 0; cm_prev_run[k] = 1'b0; cm_prev_addr[k] = 32'h0;
        end
        @(posedge sys_clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_address", address[k], 32'h0);
            chk("rst_we", write_enable[k], 4'h0);
            chk("rst_running", running[k], 1'b0);
            chk("rst_done", done[k], 1'b0);
            chk("rst_err", error_count[k], 16'h0);
        end
        @(posedge sys_clk); #2;
        sys_rst_n = 1'b1;

        // T1: mode 2, clean cache.
        run(0, 2'd2, 1'b0, -1);
        chk("t1_writes", wr_pos, 64);
        chk("t1_visits", seq_pos, 128);
        chk("t1_errors", error_count[0], 16'd0);
        chk("t1_last_addr", address[0], 32'h0000_00FC);
        chk("t1_last_data", data_in[0], 32'hA5A5_00FC);

        // T2: mode 2, read at 0x40 has bit 0 flipped.
        corrupt_en[0] = 1'b1; corrupt_addr[0] = 32'h40;
        run(0, 2'd2, 1'b0, -1);
        chk("t2_errors", error_count[0], 16'd1);
        chk("t2_first", first_err_addr[0], 32'h40);
        chk("t2_timeout", timeout_seen[0], 1'b0);
        corrupt_en[0] = 1'b0;

        // T3: mode 1, ready never arrives at 0x08.
        noready_en[0] = 1'b1; noready_addr[0] = 32'h08;
        run(0, 2'd1, 1'b0, -1);
        chk("t3_errors", error_count[0], 16'd1);
        chk("t3_first", first_err_addr[0], 32'h08);
        chk("t3_timeout", timeout_seen[0], 1'b1);
        chk("t3_writes", wr_pos, 0);
        noready_en[0] = 1'b0;

        // T4: mode 0, stride 8, inverted, busy before each request, start ignored mid-sweep.
        run(1, 2'd0, 1'b1, 10);
        chk("t4_writes", wr_pos, 4);
        chk("t4_last_data", data_in[1], 32'h5A5A_FFE7);
        chk("t4_last_addr", address[1], 32'h18);

        // T5: top of memory, single access, no wrap.
        run(2, 2'd0, 1'b0, -1);
        chk("t5_writes", wr_pos, 1);
        chk("t5_addr", address[2], 32'hFFFF_FFF8);

        // T6: mode 3 behaves as write then read at the single address.
        run(2, 2'd3, 1'b0, -1);
        chk("t6_writes", wr_pos, 1);
        chk("t6_errors", error_count[2], 16'd0);

        // T7: reset during the read phase, then a fresh sweep.
        corrupt_en[0] = 1'b1; corrupt_addr[0] = 32'h10;
        plan(0, 2'd2, 1'b0);
        kick(0, 2'd2, 1'b0);
        begin
            bit reached;
            reached = 0;
            for (int i = 0; i < 3000; i++) begin
                @(posedge sys_clk); #1;
                if (seq_pos >= 72) begin reached = 1; break; end
            end
            if (!reached) fail_now("t7_reach_timeout", seq_pos, 72);
        end
        chk("t7_pre_err", error_count[0], 16'd1);
        chk("t7_pre_running", running[0], 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_address", address[0], 32'h0);
        chk("t7_rst_data", data_in[0], 32'h0);
        chk("t7_rst_we", write_enable[0], 4'h0);
        chk("t7_rst_running", running[0], 1'b0);
        chk("t7_rst_done", done[0], 1'b0);
        chk("t7_rst_err", error_count[0], 16'h0);
        chk("t7_rst_first", first_err_addr[0], 32'h0);
        chk("t7_rst_timeout", timeout_seen[0], 1'b0);
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("t7_idle_running", running[0], 1'b0);
        chk("t7_idle_we", write_enable[0], 4'h0);
        corrupt_en[0] = 1'b0;
        run(0, 2'd1, 1'b0, -1);
        chk("t7_errors", error_count[0], 16'd0);
        chk("t7_visits", seq_pos, 64);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_exerciser.md
Name: cache_exerciser

Overview:
- Parametrised traffic generator and checker for the 32-bit cache front-end; successor to the fixed read/write-increment stimulus loop in the top level.
- Sweeps a configurable address range with a configurable stride and writes a deterministic pattern, reads it back, or does both.
- Counts mismatches and timeouts, and reports status for LEDs or UART.
- Sits between top-level control (button or start strobe) and the cache's address/data_in/write_enable/data_out/data_out_ready/busy port.

Parameters:
- ADDR_START, 0, first byte address of the sweep; must be a multiple of 4.
- ADDR_END, 32'h0000_00FC, last byte address of the sweep, inclusive.
- STRIDE, 4, address increment in bytes; must be a non-zero multiple of 4.
- PATTERN_SEED, 32'hA5A5_0000, value XORed with the address to form write and expected data.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for data_out_ready per read.
- ERR_WIDTH, 16, width of the error counter.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe; ignored unless the block is in IDLE or DONE.
- mode  in  2  sampled on start: 0 = write-only, 1 = read-verify, 2 = write then read-verify, 3 = treated as 2.
- invert  in  1  sampled on start; 1 inverts the pattern.
- address  out  32  cache address.
- data_in  out  32  cache write data.
- write_enable  out  4  cache byte enables; 4'b1111 = write, 0 = read.
- data_out  in  32  cache read data.
- data_out_ready  in  1  data_out is valid for the current address.
- busy  in  1  cache cannot accept a request.
- running  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next accepted start.
- error_count  out  ERR_WIDTH  saturating count of mismatches plus timeouts.
- first_err_addr  out  32  address of the first error; 0 if none.
- timeout_seen  out  1  at least one read timed out.

Behaviour:
- Reset is asynchronous and active-low. All outputs go to 0: address, data_in, write_enable, running, done, error_count, first_err_addr, timeout_seen. State goes to IDLE.
- Pattern function: P(a) = a ^ PATTERN_SEED, bitwise inverted when the latched invert bit is 1.
- States:
  - IDLE / DONE: on start, latch mode and invert; clear error_count, first_err_addr, timeout_seen and done; set address = ADDR_START and running = 1. Go to WR_ISSUE if mode != 1, otherwise RD_ISSUE.
  - WR_ISSUE: wait while busy = 1. When busy = 0, drive data_in = P(address) and write_enable = 4'b1111 for exactly one cycle, then go to WR_WAIT.
  - WR_WAIT: write_enable = 0. When busy = 0, go to ADV.
  - RD_ISSUE: wait while busy = 1. When busy = 0, drive write_enable = 0 with address stable, clear the timeout counter, and go to RD_WAIT.
  - RD_WAIT:
    - If data_out_ready = 1: compare data_out with P(address). On mismatch, error_count += 1. Go to ADV.
    - Else, if the counter reaches TIMEOUT_CYCLES: set timeout_seen = 1, error_count += 1, go to ADV.
    - Otherwise increment the counter.
  - ADV:
    - Compute next = address + STRIDE in 33 bits.
    - If next > ADDR_END or next[32] = 1, the phase is complete:
      - If the phase was write and mode is 2, set address = ADDR_START and go to RD_ISSUE.
      - Otherwise set running = 0, done = 1 and go to DONE.
    - If the phase is not complete, set address = next[31:0] and return to the current phase's ISSUE state.
- Error recording:
  - first_err_addr is written only on the first error of a sweep, i.e. when error_count = 0 before the increment.
  - error_count saturates at all-ones.
- Latency:
  - Write: at least 2 cycles per word when busy = 0.
  - Read: at least 2 cycles plus cache latency.
- address, data_in and write_enable change only on state transitions. address is held stable throughout RD_WAIT.
- start while running is ignored.
- If ADDR_END < ADDR_START, exactly one access is made, at ADDR_START.
- Reset mid-sweep aborts immediately; no partial write is issued after reset releases.
- busy may rise during WR_WAIT or RD_WAIT; the block waits for busy = 0 before the next issue.

Test Plan:
- Start with mode 2, defaults, and an ideal cache model (busy = 0, data_out_ready one cycle after the read) -> 64 writes with data_in = addr ^ A5A50000, then 64 reads; done = 1, error_count = 0, first_err_addr = 0.
- As above, but the model corrupts the read at 0x40 (bit 0 flipped) -> error_count = 1, first_err_addr = 0x40, timeout_seen = 0.
- Mode 1 with data_out_ready never asserting at address 0x08 -> timeout after 255 cycles at 0x08; timeout_seen = 1, error_count = 1, first_err_addr = 0x08; the sweep completes.
- Mode 0, STRIDE = 8, ADDR_END = 0x1C, invert = 1, busy held for 3 cycles before each request -> writes at 0x00, 0x08, 0x10, 0x18 only; data_in = ~(addr ^ seed); write_enable high for exactly 1 cycle each.
- ADDR_START = 0xFFFFFFF8, ADDR_END = 0xFFFFFFFC, STRIDE = 8 -> a single access, no wrap to 0; done = 1.
- sys_rst_n low during the read phase -> all outputs 0 immediately; a start pulse after reset begins a fresh sweep at ADDR_START.
